// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode, decodes ALU op, forwards operands.
// Ports: id_* decode in, exmem_*/memwb_* forward sources, ALU*/ex_* out, load_use out.
module id_ex_stage #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [15:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [1:0]  id_aluop,
  input  logic [5:0]  id_funct,
  input  logic        id_alusrc,
  input  logic        id_regdst,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        id_memtoreg,
  input  logic        stall,
  input  logic        flush,
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic [31:0] ALUin1,
  output logic [31:0] ALUin2,
  output logic [3:0]  ALUctrl,
  output logic        ex_valid,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_memtoreg,
  output logic [4:0]  ex_dest,
  output logic [31:0] ex_store_data,
  output logic        load_use
);

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        alusrc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [3:0]  aluctrl;
  } id_ex_t;

  // aluctrl is the LSB field; a bubble is all-zero with ALU op = add
  localparam id_ex_t BUB =
    id_ex_t'({{($bits(id_ex_t)-4){1'b0}}, 4'b0010});

  id_ex_t q, d, cap;
  logic [3:0]  ctrl;
  logic        funct_ok;
  logic [31:0] imm_ext;
  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;

  always_comb begin
    ctrl     = 4'b0010;
    funct_ok = 1'b1;
    unique case (id_aluop)
      2'b00: ctrl = 4'b0010;
      2'b01: ctrl = 4'b0110;
      2'b11: ctrl = 4'b0001;
      2'b10: begin
        unique case (id_funct)
          6'b100000: ctrl = 4'b0010;
          6'b100010: ctrl = 4'b0110;
          6'b100100: ctrl = 4'b0000;
          6'b100101: ctrl = 4'b0001;
          6'b101010: ctrl = 4'b0111;
          default: begin
            ctrl     = 4'b1111;
            funct_ok = 1'b0;
          end
        endcase
      end
    endcase
  end

  // logical-immediate class (ori) takes a zero-extended immediate
  assign imm_ext = (id_aluop == 2'b11) ? {16'b0, id_imm}
                                       : {{16{id_imm[15]}}, id_imm};

  assign load_use = q.valid & q.memread & id_valid &
                    (q.dest != 5'd0) &
                    ((q.dest == id_rs) | (q.dest == id_rt));

  always_comb begin
    cap = BUB;
    if (id_valid) begin
      cap.valid    = 1'b1;
      cap.regwrite = id_regwrite & funct_ok;
      cap.memread  = id_memread;
      cap.memwrite = id_memwrite;
      cap.memtoreg = id_memtoreg;
      cap.alusrc   = id_alusrc;
      cap.rs       = id_rs;
      cap.rt       = id_rt;
      cap.dest     = id_regdst ? id_rd : id_rt;
      cap.rs_data  = id_rs_data;
      cap.rt_data  = id_rt_data;
      cap.imm      = imm_ext;
      cap.aluctrl  = ctrl;
    end
  end

  // a stall holds a pending load-use bubble until the stall lifts
  always_comb begin
    d = cap;
    if (flush)         d = BUB;
    else if (stall)    d = q;
    else if (load_use) d = BUB;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= BUB;
    else     q <= d;
  end

  // EX/MEM is the younger result, so it wins over MEM/WB
  always_comb begin
    rs_fwd = q.rs_data;
    if (FWD_EN && q.rs != 5'd0) begin
      if (exmem_regwrite && exmem_rd == q.rs)
        rs_fwd = exmem_result;
      else if (memwb_regwrite && memwb_rd == q.rs)
        rs_fwd = memwb_result;
    end
  end

  always_comb begin
    rt_fwd = q.rt_data;
    if (FWD_EN && q.rt != 5'd0) begin
      if (exmem_regwrite && exmem_rd == q.rt)
        rt_fwd = exmem_result;
      else if (memwb_regwrite && memwb_rd == q.rt)
        rt_fwd = memwb_result;
    end
  end

  assign ALUin1        = rs_fwd;
  assign ALUin2        = q.alusrc ? q.imm : rt_fwd;
  assign ex_store_data = rt_fwd;
  assign ALUctrl       = q.aluctrl;
  assign ex_valid      = q.valid;
  assign ex_regwrite   = q.regwrite;
  assign ex_memread    = q.memread;
  assign ex_memwrite   = q.memwrite;
  assign ex_memtoreg   = q.memtoreg;
  assign ex_dest       = q.dest;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 FWD_EN, 1, SHALL enable operand forwarding when 1; when 0 stored register operands pass unmodified.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 id_valid  in  1  decode slot holds a real instruction.
REQ-005 id_rs_data, id_rt_data  in  32 each  register-file read data.
REQ-006 id_imm  in  16  instruction immediate.
REQ-007 id_rs, id_rt, id_rd  in  5 each  register specifiers.
REQ-008 id_aluop  in  2  main-decoder ALU class; id_funct  in  6  R-type funct.
REQ-009 id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1 each  decode controls.
REQ-010 stall  in  1  downstream back-pressure; flush  in  1  squash (branch taken).
REQ-011 exmem_regwrite in 1, exmem_rd in 5, exmem_result in 32; memwb_regwrite in 1, memwb_rd in 5, memwb_result in 32  forwarding sources.
REQ-012 ALUin1, ALUin2  out  32  ALU operands; ALUctrl  out  4  ALU operation code.
REQ-013 ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1; ex_dest  out  5; ex_store_data  out  32.
REQ-014 load_use  out  1  combinational hazard flag; decode stage SHALL hold on it.

Function
REQ-015 Per edge, priority SHALL be: flush -> bubble; else stall -> hold all state; else load_use -> bubble; else capture decode inputs.
REQ-016 Bubble SHALL load every register with its reset value (ex_valid=0, all write/mem controls 0).
REQ-017 Capture SHALL gate controls with id_valid: id_valid=0 captures a bubble.
REQ-018 ex_dest SHALL capture id_regdst ? id_rd : id_rt.
REQ-019 ALUctrl SHALL be decoded at capture and registered: aluop 00->0010, 01->0110, 11->0001, 10->by funct.
REQ-020 funct map: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111; any other funct->1111 with ex_regwrite forced 0.
REQ-021 Immediate SHALL be zero-extended when aluop=11, sign-extended otherwise, stored as 32 bits.
REQ-022 Forwarding (combinational from stored rs/rt): EX/MEM match (exmem_regwrite, exmem_rd==reg, reg!=0) SHALL win over MEM/WB match; otherwise stored data.
REQ-023 Register 0 SHALL never be forwarded.
REQ-024 ALUin1 SHALL be forwarded rs; ALUin2 SHALL be alusrc ? extended imm : forwarded rt; ex_store_data SHALL be forwarded rt regardless of alusrc.
REQ-025 load_use SHALL be ex_valid & ex_memread & id_valid & ex_dest!=0 & (ex_dest==id_rs | ex_dest==id_rt).
REQ-026 While stall=1 and load_use=1, state SHALL hold (no bubble); bubble inserted on first non-stalled edge.
REQ-027 Latency: decode inputs SHALL appear on outputs one cycle after an accepted capture.

Reset
REQ-028 rst=1 SHALL immediately, without clock, clear all stored fields to 0 and ALUctrl to 0010.
REQ-029 During and after reset: ex_valid=0, all control outputs 0, ALUin1=ALUin2=0, ex_dest=0, load_use=0.
REQ-030 rst asserted mid-stall or mid-hazard SHALL discard the held instruction; first post-reset edge captures normally.

Verification
REQ-031 Capture add r3,r1,r2 (rs_data=5, rt_data=7, aluop=10, funct=100000) -> next cycle ALUin1=5, ALUin2=7, ALUctrl=0010, ex_dest=3, ex_regwrite=1.
REQ-032 Stored rs=1, exmem(rd=1,result=0xAA,wr=1) and memwb(rd=1,result=0xBB,wr=1) -> ALUin1=0xAA; exmem_rd=0 instead -> ALUin1=0xBB; rs=0 with rd=0 matches -> stored data.
REQ-033 lw r4 in EX (memread=1, dest=4), decode id_rt=4, id_valid=1 -> load_use=1; next edge ex_valid=0, controls 0; following edge captures dependent instruction.
REQ-034 ori with id_imm=0x8001, aluop=11, alusrc=1 -> ALUin2=0x00008001, ALUctrl=0001; addi same imm, aluop=00 -> ALUin2=0xFFFF8001, ALUctrl=0010.
REQ-035 stall=1 for 3 cycles with changing decode inputs -> outputs constant; flush=1 with stall=1 -> bubble next edge; funct=000000 R-type -> ALUctrl=1111, ex_regwrite=0.
REQ-036 rst pulsed between clock edges while ex_valid=1 -> outputs match REQ-029 immediately.
